// File: rtl/alu_reservation_station_if.sv
// ---------------------------------------------------------------------------
// alu_reservation_station_if
//
// Purpose: bundles the dispatch, writeback-snoop and ALU-issue signals of the
// ALU reservation station so they travel as one port.
//
// Modports:
//   master : the surrounding pipeline (dispatch stage, writeback bus, ALU).
//            Drives disp_*, wb_*, fu_ready; observes disp_ready, the issue
//            bundle and count.
//   slave  : the reservation station itself (mirror of master).
//
// Signal summary:
//   disp_valid / disp_ready      dispatch handshake
//   disp_ALUOp .. disp_robn      dispatched instruction fields
//   wb_valid / wb_reg            writeback broadcast of a completed tag
//   fu_ready                     ALU can accept an issue this cycle
//   issue, ALUOp .. out_robn     registered issue bundle towards the ALU
//   count                        occupied station entries
// ---------------------------------------------------------------------------
interface alu_reservation_station_if #(
    parameter int REG_NUM    = 64,
    parameter int ALUOP_BITS = 3,
    parameter int SIZE       = 32,
    parameter int ROB_ROWS   = 16,
    parameter int RS_ROWS    = 8
);
    localparam int TAG_W = $clog2(REG_NUM);
    localparam int ROB_W = $clog2(ROB_ROWS);
    localparam int CNT_W = $clog2(RS_ROWS) + 1;

    // Dispatch side
    logic                  disp_valid;
    logic                  disp_ready;
    logic [ALUOP_BITS-1:0] disp_ALUOp;
    logic [TAG_W-1:0]      disp_src_reg1;
    logic [TAG_W-1:0]      disp_src_reg2;
    logic                  disp_src1_rdy;
    logic                  disp_src2_rdy;
    logic                  disp_use_imm;
    logic [SIZE-1:0]       disp_imm;
    logic [TAG_W-1:0]      disp_dest_reg1;
    logic [ROB_W-1:0]      disp_robn;

    // Writeback snoop
    logic                  wb_valid;
    logic [TAG_W-1:0]      wb_reg;

    // Issue side
    logic                  fu_ready;
    logic                  issue;
    logic [ALUOP_BITS-1:0] ALUOp;
    logic [TAG_W-1:0]      src_reg1;
    logic [TAG_W-1:0]      src_reg2;
    logic                  use_imm;
    logic [SIZE-1:0]       imm;
    logic [TAG_W-1:0]      dest_reg1;
    logic [ROB_W-1:0]      out_robn;
    logic [CNT_W-1:0]      count;

    modport master (
        output disp_valid, disp_ALUOp, disp_src_reg1, disp_src_reg2,
               disp_src1_rdy, disp_src2_rdy, disp_use_imm, disp_imm,
               disp_dest_reg1, disp_robn, wb_valid, wb_reg, fu_ready,
        input  disp_ready, issue, ALUOp, src_reg1, src_reg2, use_imm, imm,
               dest_reg1, out_robn, count
    );

    modport slave (
        input  disp_valid, disp_ALUOp, disp_src_reg1, disp_src_reg2,
               disp_src1_rdy, disp_src2_rdy, disp_use_imm, disp_imm,
               disp_dest_reg1, disp_robn, wb_valid, wb_reg, fu_ready,
        output disp_ready, issue, ALUOp, src_reg1, src_reg2, use_imm, imm,
               dest_reg1, out_robn, count
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//
// Purpose: in-order-allocate, out-of-order-issue reservation station in front
// of the ALU. Entries are kept in a collapsing queue (index 0 = oldest). Each
// cycle the oldest entry whose two sources are ready is issued to the ALU
// (if fu_ready), and the entries above it shift down one place. Waiting
// entries snoop the writeback broadcast to set their ready bits.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every entry and the outputs
//   rs   : alu_reservation_station_if.slave (dispatch, writeback, issue)
//
// Build option:
//   RS_DISPATCH_BYPASS_EN - when defined, a writeback broadcast in the same
//   cycle as a dispatch also sets the matching ready bit of the entry being
//   written. When undefined, the dispatched ready bits are taken verbatim.
// ---------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int REG_NUM    = 64,
    parameter int ALUOP_BITS = 3,
    parameter int SIZE       = 32,
    parameter int ROB_ROWS   = 16,
    parameter int RS_ROWS    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_reservation_station_if.slave   rs
);
    localparam int TAG_W = $clog2(REG_NUM);
    localparam int ROB_W = $clog2(ROB_ROWS);
    localparam int IDX_W = $clog2(RS_ROWS);
    localparam int CNT_W = IDX_W + 1;

    // Fields that travel unchanged from dispatch to the issue bundle.
    typedef struct packed {
        logic [ALUOP_BITS-1:0] op;
        logic [TAG_W-1:0]      src1;
        logic [TAG_W-1:0]      src2;
        logic                  use_imm;
        logic [SIZE-1:0]       imm;
        logic [TAG_W-1:0]      dest;
        logic [ROB_W-1:0]      robn;
    } bundle_t;

    typedef struct packed {
        logic    valid;
        logic    r1;
        logic    r2;
        bundle_t b;
    } entry_t;

    entry_t           r_ent  [RS_ROWS];
    entry_t           w_next [RS_ROWS];
    logic [CNT_W-1:0] r_count;
    logic             r_issue;
    bundle_t          r_out;

    logic [RS_ROWS-1:0] w_rdy;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_disp_ready;
    logic               w_do_disp;
    logic               w_do_issue;
    logic [CNT_W-1:0]   w_wpos;
    logic               w_byp1;
    logic               w_byp2;
    entry_t             w_new;

    // -----------------------------------------------------------------------
    // Handshake and write position
    // -----------------------------------------------------------------------
    // disp_ready deliberately ignores a same-cycle issue, so a full station
    // stalls dispatch for one cycle rather than chaining issue into ready.
    assign w_disp_ready = (r_count < CNT_W'(RS_ROWS));
    assign w_do_disp    = rs.disp_valid && w_disp_ready;
    assign w_do_issue   = rs.fu_ready && w_sel_found;
    // The queue is collapsed, so the first free slot is count; an issue at the
    // same edge removes one entry below it, pulling the slot down by one.
    assign w_wpos       = w_do_issue ? (r_count - CNT_W'(1)) : r_count;

`ifdef RS_DISPATCH_BYPASS_EN
    assign w_byp1 = rs.wb_valid && (rs.wb_reg == rs.disp_src_reg1);
    assign w_byp2 = rs.wb_valid && (rs.wb_reg == rs.disp_src_reg2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        w_new           = '0;
        w_new.valid     = 1'b1;
        w_new.r1        = rs.disp_src1_rdy | w_byp1;
        // An immediate operand never waits on src2.
        w_new.r2        = rs.disp_src2_rdy | rs.disp_use_imm | w_byp2;
        w_new.b.op      = rs.disp_ALUOp;
        w_new.b.src1    = rs.disp_src_reg1;
        w_new.b.src2    = rs.disp_src_reg2;
        w_new.b.use_imm = rs.disp_use_imm;
        w_new.b.imm     = rs.disp_imm;
        w_new.b.dest    = rs.disp_dest_reg1;
        w_new.b.robn    = rs.disp_robn;
    end

    // -----------------------------------------------------------------------
    // Oldest-ready selection from registered state only
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        // Walk from the top down so the lowest ready index is the last write.
        for (int i = RS_ROWS - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-entry next state: collapse, wakeup, then dispatch write
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < RS_ROWS; gi++) begin : g_ent
        localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
        localparam logic [CNT_W-1:0] POS = CNT_W'(gi);

        entry_t w_up;
        entry_t w_kept;

        if (gi < RS_ROWS - 1) begin : g_up
            assign w_up = r_ent[gi + 1];
        end else begin : g_top
            assign w_up = '0;
        end

        assign w_rdy[gi] = r_ent[gi].valid & r_ent[gi].r1 & r_ent[gi].r2;

        always_comb begin
            // Entries at or above the issued slot take their upper neighbour;
            // the issued entry itself disappears and never sees the wakeup.
            w_kept = (w_do_issue && (w_sel_idx <= IDX)) ? w_up : r_ent[gi];
            if (rs.wb_valid && w_kept.valid) begin
                if (w_kept.b.src1 == rs.wb_reg) begin
                    w_kept.r1 = 1'b1;
                end
                if (w_kept.b.src2 == rs.wb_reg) begin
                    w_kept.r2 = 1'b1;
                end
            end
        end

        assign w_next[gi] = (w_do_disp && (w_wpos == POS)) ? w_new : w_kept;
    end

    // -----------------------------------------------------------------------
    // State registers and issue bundle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_ROWS; i++) begin
                r_ent[i] <= '0;
            end
            r_count <= '0;
            r_issue <= 1'b0;
            r_out   <= '0;
        end else begin
            for (int i = 0; i < RS_ROWS; i++) begin
                r_ent[i] <= w_next[i];
            end
            case ({w_do_disp, w_do_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_issue <= w_do_issue;
            // Bundle holds its last value when nothing issues.
            if (w_do_issue) begin
                r_out <= r_ent[w_sel_idx].b;
            end
        end
    end

    assign rs.disp_ready = w_disp_ready;
    assign rs.count      = r_count;
    assign rs.issue      = r_issue;
    assign rs.ALUOp      = r_out.op;
    assign rs.src_reg1   = r_out.src1;
    assign rs.src_reg2   = r_out.src2;
    assign rs.use_imm    = r_out.use_imm;
    assign rs.imm        = r_out.imm;
    assign rs.dest_reg1  = r_out.dest;
    assign rs.out_robn   = r_out.robn;

endmodule

// File: tb/tb_alu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_alu_reservation_station
//
// Directed scenarios followed by a randomized run. Every clock step is
// predicted by a queue-based reference model (oldest-ready issue, wakeup,
// append on dispatch) and the DUT outputs are compared one step at a time.
// ---------------------------------------------------------------------------
module tb_alu_reservation_station;
    localparam int REG_NUM    = 64;
    localparam int ALUOP_BITS = 3;
    localparam int SIZE       = 32;
    localparam int ROB_ROWS   = 16;
    localparam int RS_ROWS    = 8;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic        uimm;
        logic [31:0] imm;
        logic [5:0]  dest;
        logic [3:0]  robn;
        bit          r1;
        bit          r2;
    } m_ent_t;

    logic clk;
    logic rst;

    alu_reservation_station_if #(
        .REG_NUM(REG_NUM), .ALUOP_BITS(ALUOP_BITS), .SIZE(SIZE),
        .ROB_ROWS(ROB_ROWS), .RS_ROWS(RS_ROWS)
    ) bus ();

    alu_reservation_station #(
        .REG_NUM(REG_NUM), .ALUOP_BITS(ALUOP_BITS), .SIZE(SIZE),
        .ROB_ROWS(ROB_ROWS), .RS_ROWS(RS_ROWS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    m_ent_t      mq[$];
    bit          m_issue = 1'b0;
    logic [57:0] m_bundle = '0;

    function automatic logic [57:0] pack(input m_ent_t e);
        return {e.op, e.s1, e.s2, e.uimm, e.imm, e.dest, e.robn};
    endfunction

    function automatic logic [57:0] dut_bundle();
        return {bus.ALUOp, bus.src_reg1, bus.src_reg2, bus.use_imm, bus.imm,
                bus.dest_reg1, bus.out_robn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict with the model, then compare after the edge.
    task automatic step();
        int     sel;
        bit     rdy;
        m_ent_t e;
        if (rst) begin
            mq.delete();
            m_issue  = 1'b0;
            m_bundle = '0;
        end else begin
            rdy = (mq.size() < RS_ROWS);
            sel = -1;
            foreach (mq[i]) begin
                if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            end
            m_issue = 1'b0;
            if (bus.fu_ready && sel >= 0) begin
                m_issue  = 1'b1;
                m_bundle = pack(mq[sel]);
                mq.delete(sel);
            end
            if (bus.wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].s1 == bus.wb_reg) mq[i].r1 = 1'b1;
                    if (mq[i].s2 == bus.wb_reg) mq[i].r2 = 1'b1;
                end
            end
            if (bus.disp_valid && rdy) begin
                e.op   = bus.disp_ALUOp;
                e.s1   = bus.disp_src_reg1;
                e.s2   = bus.disp_src_reg2;
                e.uimm = bus.disp_use_imm;
                e.imm  = bus.disp_imm;
                e.dest = bus.disp_dest_reg1;
                e.robn = bus.disp_robn;
                e.r1   = bus.disp_src1_rdy;
                e.r2   = bus.disp_src2_rdy || bus.disp_use_imm;
`ifdef RS_DISPATCH_BYPASS_EN
                if (bus.wb_valid && bus.wb_reg == e.s1) e.r1 = 1'b1;
                if (bus.wb_valid && bus.wb_reg == e.s2) e.r2 = 1'b1;
`endif
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("issue", 64'(bus.issue), 64'(m_issue));
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < RS_ROWS));
        chk("bundle", 64'(dut_bundle()), 64'(m_bundle));
    endtask

    task automatic drv(input logic [5:0] s1, input logic [5:0] s2,
                       input bit r1, input bit r2, input bit uimm,
                       input logic [31:0] imm, input logic [2:0] op,
                       input logic [5:0] dest, input logic [3:0] robn);
        bus.disp_valid     = 1'b1;
        bus.disp_src_reg1  = s1;
        bus.disp_src_reg2  = s2;
        bus.disp_src1_rdy  = r1;
        bus.disp_src2_rdy  = r2;
        bus.disp_use_imm   = uimm;
        bus.disp_imm       = imm;
        bus.disp_ALUOp     = op;
        bus.disp_dest_reg1 = dest;
        bus.disp_robn      = robn;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.wb_valid   = 1'b0;
    endtask

    task automatic wb(input logic [5:0] tag);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = tag;
    endtask

    initial begin
        int exp_order[7] = '{0, 1, 2, 4, 5, 6, 7};

        rst = 1'b1;
        bus.fu_ready = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        wb(0);
        idle();

        // Reset state
        step();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_issue", 64'(bus.issue), 64'd0);
        rst = 1'b0;

        // Ready ADD issues one cycle after dispatch
        bus.fu_ready = 1'b1;
        drv(3, 4, 1, 1, 0, 0, 3'd1, 10, 2);
        step();
        chk("t1_no_issue_yet", 64'(bus.issue), 64'd0);
        idle();
        step();
        chk("t1_issue", 64'(bus.issue), 64'd1);
        chk("t1_op", 64'(bus.ALUOp), 64'd1);
        chk("t1_src1", 64'(bus.src_reg1), 64'd3);
        chk("t1_src2", 64'(bus.src_reg2), 64'd4);
        chk("t1_dest", 64'(bus.dest_reg1), 64'd10);
        chk("t1_robn", 64'(bus.out_robn), 64'd2);
        chk("t1_count", 64'(bus.count), 64'd0);
        step();
        chk("t1_one_cycle", 64'(bus.issue), 64'd0);

        // Younger ready entry overtakes an older waiting one
        drv(5, 6, 0, 1, 0, 0, 3'd2, 11, 4);
        step();
        drv(1, 2, 1, 1, 0, 0, 3'd3, 12, 5);
        step();
        idle();
        step();
        chk("t2_b_first", 64'(bus.out_robn), 64'd5);
        wb(5);
        step();
        chk("t2_wake_edge", 64'(bus.issue), 64'd0);
        idle();
        step();
        chk("t2_a_issue", 64'(bus.issue), 64'd1);
        chk("t2_a_robn", 64'(bus.out_robn), 64'd4);

        // Fill, overflow ignored, middle issue then age order preserved
        bus.fu_ready = 1'b0;
        for (int i = 0; i < RS_ROWS; i++) begin
            drv(6'(20 + i), 40, 0, 1, 0, 0, 3'd4, 6'(30 + i), 4'(i));
            step();
        end
        chk("t3_full_ready", 64'(bus.disp_ready), 64'd0);
        chk("t3_full_count", 64'(bus.count), 64'd8);
        drv(1, 2, 1, 1, 0, 0, 3'd4, 50, 15);
        step();
        chk("t3_ninth_ignored", 64'(bus.count), 64'd8);
        idle();
        bus.fu_ready = 1'b1;
        wb(23);
        step();
        idle();
        step();
        chk("t3_mid_issue", 64'(bus.out_robn), 64'd3);
        chk("t3_mid_count", 64'(bus.count), 64'd7);
        bus.fu_ready = 1'b0;
        wb(27); step();
        wb(26); step();
        wb(25); step();
        wb(24); step();
        wb(20); step();
        wb(21); step();
        wb(22); step();
        idle();
        bus.fu_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("t3_order", 64'(bus.out_robn), 64'(exp_order[k]));
        end

        // fu_ready low holds issue off; then oldest, then younger
        bus.fu_ready = 1'b0;
        drv(1, 2, 1, 1, 0, 0, 3'd2, 15, 8);
        step();
        drv(3, 4, 1, 1, 0, 0, 3'd2, 16, 9);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_held", 64'(bus.issue), 64'd0);
        end
        bus.fu_ready = 1'b1;
        step();
        chk("t4_older", 64'(bus.out_robn), 64'd8);
        step();
        chk("t4_younger", 64'(bus.out_robn), 64'd9);

        // Immediate operand ignores src2 readiness
        drv(1, 30, 1, 0, 1, 32'hFFFF_FFF0, 3'd5, 13, 10);
        step();
        idle();
        step();
        chk("t5_issue", 64'(bus.issue), 64'd1);
        chk("t5_imm", 64'(bus.imm), 64'hFFFF_FFF0);
        chk("t5_use_imm", 64'(bus.use_imm), 64'd1);

        // Broadcast in the dispatch cycle
        drv(7, 8, 0, 1, 0, 0, 3'd6, 14, 11);
        wb(7);
        step();
        idle();
        step();
`ifdef RS_DISPATCH_BYPASS_EN
        chk("t6_bypass_issue", 64'(bus.issue), 64'd1);
        chk("t6_bypass_robn", 64'(bus.out_robn), 64'd11);
`else
        chk("t6_no_bypass", 64'(bus.issue), 64'd0);
        step();
        step();
        chk("t6_still_waiting", 64'(bus.count), 64'd1);
`endif

        // Reset with entries held
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1, 2, 1, 1, 0, 0, 3'd1, 6'(i), 4'(i));
            step();
        end
        idle();
        rst = 1'b1;
        step();
        chk("t7_rst_count", 64'(bus.count), 64'd0);
        chk("t7_rst_issue", 64'(bus.issue), 64'd0);
        rst = 1'b0;

        // Randomized traffic on a small tag range to stress wakeup
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(99) == 0);
            bus.disp_valid     = ($urandom_range(9) < 6);
            bus.disp_src_reg1  = 6'($urandom_range(7));
            bus.disp_src_reg2  = 6'($urandom_range(7));
            bus.disp_src1_rdy  = 1'($urandom_range(1));
            bus.disp_src2_rdy  = 1'($urandom_range(1));
            bus.disp_use_imm   = ($urandom_range(3) == 0);
            bus.disp_imm       = $urandom;
            bus.disp_ALUOp     = 3'($urandom_range(7));
            bus.disp_dest_reg1 = 6'($urandom_range(63));
            bus.disp_robn      = 4'($urandom_range(15));
            bus.wb_valid       = 1'($urandom_range(1));
            bus.wb_reg         = 6'($urandom_range(7));
            bus.fu_ready       = ($urandom_range(9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
